// File: rtl/valu_wb_sink.sv
// valu_wb_sink: receive end of the vector ALU result stream.
// Vector results are queued in a FIFO and drained to the VRF write port under valid/ready.
// Scalar results go to a one-entry holding register. The ALU pipelines cannot stall,
// so issue_stall is raised while the free FIFO space is no more than the in-flight bound.
module valu_wb_sink #(
    parameter int unsigned REQ_ADDR_WIDTH  = 32,
    parameter int unsigned RESP_DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned PIPE_LAT        = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    // result stream from the ALU lanes
    input  logic                             in_valid,
    input  logic [REQ_ADDR_WIDTH-1:0]        in_addr,
    input  logic [RESP_DATA_WIDTH-1:0]       in_vec,
    input  logic                             in_w_reg,
    input  logic                             in_sca,
    // VRF write port
    output logic                             vrf_wr_valid,
    output logic [REQ_ADDR_WIDTH-1:0]        vrf_wr_addr,
    output logic [RESP_DATA_WIDTH-1:0]       vrf_wr_data,
    input  logic                             vrf_wr_ready,
    // scalar response path
    output logic                             sca_valid,
    output logic [RESP_DATA_WIDTH-1:0]       sca_data,
    input  logic                             sca_ready,
    // status
    output logic                             issue_stall,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
    output logic                             ovf_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    // Stall once free space (FIFO_DEPTH - count) drops to PIPE_LAT or less.
    localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(FIFO_DEPTH - PIPE_LAT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // FIFO storage and pointers
    logic [REQ_ADDR_WIDTH-1:0]  r_addr_mem [FIFO_DEPTH];
    logic [RESP_DATA_WIDTH-1:0] r_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [CNT_W-1:0]           r_count;

    // scalar holding register and sticky error
    logic                       r_sca_valid;
    logic [RESP_DATA_WIDTH-1:0] r_sca_data;
    logic                       r_ovf_err;

    // handshake decode
    logic w_full;
    logic w_empty;
    logic w_push_req;
    logic w_pop;
    logic w_push;
    logic w_vec_drop;
    logic w_sca_load;
    logic w_sca_accept;
    logic w_sca_take;
    logic w_sca_drop;

    // Decode push/pop and scalar load/accept for this cycle.
    always_comb begin
        w_full       = (r_count == FULL_CNT);
        w_empty      = (r_count == '0);
        w_push_req   = in_valid & in_w_reg;
        w_pop        = ~w_empty & vrf_wr_ready;
        // A full FIFO still accepts when the head leaves in the same cycle.
        w_push       = w_push_req & (~w_full | w_pop);
        w_vec_drop   = w_push_req & w_full & ~w_pop;
        w_sca_load   = in_valid & in_sca;
        w_sca_accept = r_sca_valid & sca_ready;
        w_sca_take   = w_sca_load & (~r_sca_valid | w_sca_accept);
        w_sca_drop   = w_sca_load & r_sca_valid & ~w_sca_accept;
    end

    // FIFO storage writes; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_addr_mem[i] <= '0;
                r_data_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_addr_mem[r_wr_ptr] <= in_addr;
            r_data_mem[r_wr_ptr] <= in_vec;
        end
    end

    // FIFO pointers and occupancy count; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Scalar holding register: load when empty or being accepted, otherwise drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sca_valid <= 1'b0;
            r_sca_data  <= '0;
        end else if (w_sca_take) begin
            r_sca_valid <= 1'b1;
            r_sca_data  <= in_vec;
        end else if (w_sca_accept) begin
            r_sca_valid <= 1'b0;
        end
    end

    // Sticky overflow flag for any dropped vector or scalar result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
        end else if (w_vec_drop || w_sca_drop) begin
            r_ovf_err <= 1'b1;
        end
    end

    // Outputs come straight from registered state; no input-to-output paths.
    always_comb begin
        vrf_wr_valid = ~w_empty;
        vrf_wr_addr  = r_addr_mem[r_rd_ptr];
        vrf_wr_data  = r_data_mem[r_rd_ptr];
        sca_valid    = r_sca_valid;
        sca_data     = r_sca_data;
        fifo_count   = r_count;
        issue_stall  = (r_count >= STALL_AT);
        ovf_err      = r_ovf_err;
    end

endmodule

// File: tb/tb_valu_wb_sink.sv
// Self-checking bench for valu_wb_sink: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based behavioural model.
module tb_valu_wb_sink;

    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int DEPTH = 8;
    localparam int LAT   = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic [DW-1:0] in_vec = '0;
    logic          in_w_reg = 1'b0;
    logic          in_sca = 1'b0;
    logic          vrf_wr_valid;
    logic [AW-1:0] vrf_wr_addr;
    logic [DW-1:0] vrf_wr_data;
    logic          vrf_wr_ready = 1'b0;
    logic          sca_valid;
    logic [DW-1:0] sca_data;
    logic          sca_ready = 1'b0;
    logic          issue_stall;
    logic [3:0]    fifo_count;
    logic          ovf_err;

    always #5 clk = ~clk;

    valu_wb_sink #(
        .REQ_ADDR_WIDTH (AW),
        .RESP_DATA_WIDTH(DW),
        .FIFO_DEPTH     (DEPTH),
        .PIPE_LAT       (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_addr     (in_addr),
        .in_vec      (in_vec),
        .in_w_reg    (in_w_reg),
        .in_sca      (in_sca),
        .vrf_wr_valid(vrf_wr_valid),
        .vrf_wr_addr (vrf_wr_addr),
        .vrf_wr_data (vrf_wr_data),
        .vrf_wr_ready(vrf_wr_ready),
        .sca_valid   (sca_valid),
        .sca_data    (sca_data),
        .sca_ready   (sca_ready),
        .issue_stall (issue_stall),
        .fifo_count  (fifo_count),
        .ovf_err     (ovf_err)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    // behavioural model state
    ent_t          mq[$];
    bit            m_sv;
    logic [DW-1:0] m_sd;
    bit            m_ovf;
    bit            m_fresh;
    bit            m_pop;
    bit            m_acc;

    // addresses the DUT actually wrote to the VRF
    logic [AW-1:0] dut_log[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h", name, got, want);
    endtask

    // model: apply the specification's rules at each edge
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_sv    = 1'b0;
            m_sd    = '0;
            m_ovf   = 1'b0;
            m_fresh = 1'b1;
        end else begin
            m_pop = (mq.size() != 0) && vrf_wr_ready;
            m_acc = m_sv && sca_ready;
            if (m_pop) void'(mq.pop_front());
            if (in_valid && in_w_reg) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(ent_t'{a: in_addr, d: in_vec});
                    m_fresh = 1'b0;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (in_valid && in_sca) begin
                if (!m_sv || m_acc) begin
                    m_sv = 1'b1;
                    m_sd = in_vec;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_acc) begin
                m_sv = 1'b0;
            end
        end
    end

    // record VRF writes seen on the DUT port
    always @(posedge clk) begin
        if (!rst && vrf_wr_valid && vrf_wr_ready) dut_log.push_back(vrf_wr_addr);
    end

    // compare DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        check("vrf_wr_valid", 64'(vrf_wr_valid), 64'(mq.size() != 0));
        check("fifo_count", 64'(fifo_count), 64'(mq.size()));
        check("issue_stall", 64'(issue_stall), 64'((DEPTH - mq.size()) <= LAT));
        check("ovf_err", 64'(ovf_err), 64'(m_ovf));
        check("sca_valid", 64'(sca_valid), 64'(m_sv));
        check("sca_data", sca_data, m_sd);
        if (mq.size() != 0) begin
            check("vrf_wr_addr", 64'(vrf_wr_addr), 64'(mq[0].a));
            check("vrf_wr_data", vrf_wr_data, mq[0].d);
        end else if (m_fresh) begin
            check("vrf_wr_addr_rst", 64'(vrf_wr_addr), 64'd0);
            check("vrf_wr_data_rst", vrf_wr_data, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_w_reg = 1'b0;
        in_sca   = 1'b0;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                        input logic s);
        in_valid = 1'b1;
        in_addr  = a;
        in_vec   = d;
        in_w_reg = w;
        in_sca   = s;
        tick();
        idle_in();
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bit ok;
        int k;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 64'(vrf_wr_valid), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_stall", 64'(issue_stall), 64'd0);
        check("rst_ovf", 64'(ovf_err), 64'd0);

        // idle with garbage on the qualified fields
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b0;
            in_addr  = $urandom;
            in_vec   = {$urandom, $urandom};
            in_w_reg = 1'($urandom);
            in_sca   = 1'($urandom);
            tick();
        end
        idle_in();
        check("idle_count", 64'(fifo_count), 64'd0);

        // single push, hold, then pop
        vrf_wr_ready = 1'b0;
        send(32'h10, 64'hA5A5, 1'b1, 1'b0);
        check("push_valid", 64'(vrf_wr_valid), 64'd1);
        check("push_count", 64'(fifo_count), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_addr", 64'(vrf_wr_addr), 64'h10);
            check("hold_data", vrf_wr_data, 64'hA5A5);
        end
        vrf_wr_ready = 1'b1;
        tick();
        vrf_wr_ready = 1'b0;
        check("pop_valid", 64'(vrf_wr_valid), 64'd0);

        // fill, stall threshold, overflow, push+pop at full
        send(32'h100, 64'h1000, 1'b1, 1'b0);
        check("stall_at1", 64'(issue_stall), 64'd0);
        send(32'h101, 64'h1001, 1'b1, 1'b0);
        check("stall_at2", 64'(issue_stall), 64'd1);
        for (int i = 2; i < 8; i++) send(32'h100 + 32'(i), 64'h1000 + 64'(i), 1'b1, 1'b0);
        check("full_count", 64'(fifo_count), 64'd8);
        send(32'hDEAD, 64'hDEAD, 1'b1, 1'b0);
        check("ovf_set", 64'(ovf_err), 64'd1);
        check("ovf_count", 64'(fifo_count), 64'd8);
        check("ovf_head", 64'(vrf_wr_addr), 64'h100);
        dut_log.delete();
        vrf_wr_ready = 1'b1;
        send(32'h200, 64'h2000, 1'b1, 1'b0);
        check("pp_count", 64'(fifo_count), 64'd8);
        check("pp_head", 64'(vrf_wr_addr), 64'h101);
        for (int i = 0; i < 8; i++) tick();
        vrf_wr_ready = 1'b0;
        check("drain_count", 64'(fifo_count), 64'd0);
        check("drain_len", 64'(dut_log.size()), 64'd9);
        ok = (dut_log.size() == 9);
        for (int i = 0; i < 8 && ok; i++) if (dut_log[i] !== 32'h100 + 32'(i)) ok = 1'b0;
        if (ok && dut_log[8] !== 32'h200) ok = 1'b0;
        check("drain_order", 64'(ok), 64'd1);

        // wrap-around with continuous push/pop
        do_reset();
        dut_log.delete();
        vrf_wr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(32'(i), 64'(i) ^ 64'hF0F0, 1'b1, 1'b0);
            check("wrap_count_le1", 64'(fifo_count <= 4'd1), 64'd1);
        end
        tick();
        vrf_wr_ready = 1'b0;
        check("wrap_len", 64'(dut_log.size()), 64'd20);
        ok = (dut_log.size() == 20);
        for (int i = 0; i < 20 && ok; i++) if (dut_log[i] !== 32'(i)) ok = 1'b0;
        check("wrap_order", 64'(ok), 64'd1);

        // scalar path
        do_reset();
        sca_ready = 1'b0;
        send(32'h0, 64'h1234, 1'b0, 1'b1);
        check("sca_v1", 64'(sca_valid), 64'd1);
        check("sca_d1", sca_data, 64'h1234);
        send(32'h0, 64'h5678, 1'b0, 1'b1);
        check("sca_ovf", 64'(ovf_err), 64'd1);
        check("sca_d2", sca_data, 64'h1234);
        sca_ready = 1'b1;
        send(32'h0, 64'h9ABC, 1'b0, 1'b1);
        check("sca_v3", 64'(sca_valid), 64'd1);
        check("sca_d3", sca_data, 64'h9ABC);
        tick();
        sca_ready = 1'b0;
        check("sca_clr", 64'(sca_valid), 64'd0);

        // dual flag, then reset with entries queued and handshakes active
        do_reset();
        send(32'h40, 64'hFF, 1'b1, 1'b1);
        check("dual_vv", 64'(vrf_wr_valid), 64'd1);
        check("dual_vd", vrf_wr_data, 64'hFF);
        check("dual_sv", 64'(sca_valid), 64'd1);
        check("dual_sd", sca_data, 64'hFF);
        for (int i = 1; i < 4; i++) send(32'h40 + 32'(i), 64'h77, 1'b1, 1'b0);
        check("q4_count", 64'(fifo_count), 64'd4);
        rst          = 1'b1;
        in_valid     = 1'b1;
        in_w_reg     = 1'b1;
        in_sca       = 1'b1;
        vrf_wr_ready = 1'b1;
        sca_ready    = 1'b1;
        tick();
        rst = 1'b0;
        idle_in();
        vrf_wr_ready = 1'b0;
        sca_ready    = 1'b0;
        check("mr_count", 64'(fifo_count), 64'd0);
        check("mr_vv", 64'(vrf_wr_valid), 64'd0);
        check("mr_va", 64'(vrf_wr_addr), 64'd0);
        check("mr_vd", vrf_wr_data, 64'd0);
        check("mr_sv", 64'(sca_valid), 64'd0);
        check("mr_sd", sca_data, 64'd0);
        check("mr_ovf", 64'(ovf_err), 64'd0);
        check("mr_stall", 64'(issue_stall), 64'd0);

        // randomized traffic; issuer mostly honours the stall
        for (int i = 0; i < 3000; i++) begin
            k = int'($urandom_range(0, 9));
            rst          = ($urandom_range(0, 299) == 0);
            in_valid     = ($urandom_range(0, 3) != 0) &&
                           (((DEPTH - mq.size()) > LAT) || k == 0);
            in_addr      = $urandom;
            in_vec       = {$urandom, $urandom};
            in_w_reg     = ($urandom_range(0, 3) != 0);
            in_sca       = ($urandom_range(0, 3) == 0);
            vrf_wr_ready = ($urandom_range(0, 2) != 0);
            sca_ready    = 1'($urandom);
            tick();
        end
        rst = 1'b0;
        idle_in();
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
